// File: rtl/fir_mc_engine.sv
// fir_mc_engine: multi-channel FIR engine, taps from h stream, interleaved x in, rescaled y out
//   clk_i/rst_ni          : clock, async active-low reset
//   clear_i               : sync soft clear (aborts job, invalidates taps)
//   start_i/reload_taps_i : job start, force coefficient reload
//   length_i              : samples per channel; right_shift_i/round_i/saturate_i: output rescale
//   h_*                   : coefficient stream in; x_* : sample stream in; y_* : result stream out
//   busy_o/done_o         : job active, one-cycle end-of-job pulse
module fir_mc_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int NB_TAPS     = 8,
    parameter int NB_CHANNELS = 2,
    localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NB_TAPS),
    localparam int CH_WIDTH   = NB_CHANNELS > 1 ? $clog2(NB_CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic                  reload_taps_i,
    input  logic [15:0]           length_i,
    input  logic [5:0]            right_shift_i,
    input  logic                  round_i,
    input  logic                  saturate_i,
    input  logic                  h_valid_i,
    output logic                  h_ready_o,
    input  logic [DATA_WIDTH-1:0] h_data_i,
    input  logic                  x_valid_i,
    output logic                  x_ready_o,
    input  logic [DATA_WIDTH-1:0] x_data_i,
    output logic                  y_valid_o,
    input  logic                  y_ready_i,
    output logic [DATA_WIDTH-1:0] y_data_o,
    output logic [CH_WIDTH-1:0]   y_chan_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int TW   = $clog2(NB_TAPS);
    localparam int SMAX = ACC_WIDTH - 1 > 63 ? 63 : ACC_WIDTH - 1;
    localparam logic signed [ACC_WIDTH:0] YMAX = $signed({{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] YMIN = ~YMAX;

    typedef enum logic [1:0] {IDLE, TAP_LOAD, COMPUTE} state_t;
    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] taps [NB_TAPS];
    // dl[c][k] holds x_c[n-1-k]; the incoming sample supplies the k=0 term
    logic signed [DATA_WIDTH-1:0] dl [NB_CHANNELS][NB_TAPS-1];
    logic                         taps_valid;
    logic [TW-1:0]                tap_cnt;
    logic [CH_WIDTH-1:0]          ch;
    logic [31:0]                  remaining;
    logic [5:0]                   rshift;
    logic                         rnd;
    logic                         sat;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH:0]    rnd_acc;
    logic signed [ACC_WIDTH:0]    shifted;
    logic [5:0]                   s;
    logic [DATA_WIDTH-1:0]        y_next;
    logic                         h_fire;
    logic                         x_fire;
    logic                         y_fire;
    logic                         last;

    assign h_ready_o = state_q == TAP_LOAD;
    assign x_ready_o = state_q == COMPUTE && remaining != 0 && (!y_valid_o || y_ready_i);
    assign busy_o    = state_q != IDLE;
    assign h_fire    = h_valid_i && h_ready_o;
    assign x_fire    = x_valid_i && x_ready_o;
    assign y_fire    = y_valid_o && y_ready_i;
    // job ends once every sample is in and the output register drains (covers length 0)
    assign last      = state_q == COMPUTE && remaining == 0 && (!y_valid_o || y_ready_i);

    always_comb begin
        state_d = state_q;
        if (clear_i)
            state_d = IDLE;
        else if (state_q == IDLE && start_i)
            state_d = (reload_taps_i || !taps_valid) ? TAP_LOAD : COMPUTE;
        else if (h_fire && tap_cnt == TW'(NB_TAPS-1))
            state_d = COMPUTE;
        else if (last)
            state_d = IDLE;
    end

    always_comb begin
        acc = ACC_WIDTH'(taps[0]) * ACC_WIDTH'($signed(x_data_i));
        for (int k = 1; k < NB_TAPS; k++)
            acc = acc + ACC_WIDTH'(taps[k]) * ACC_WIDTH'(dl[ch][k-1]);
        s       = rshift > 6'(SMAX) ? 6'(SMAX) : rshift;
        // one guard bit keeps the rounding add from wrapping
        rnd_acc = (ACC_WIDTH+1)'(acc) + ((rnd && s != 0) ? (ACC_WIDTH+1)'(1) << (s - 6'd1) : '0);
        shifted = rnd_acc >>> s;
        y_next  = !sat          ? shifted[DATA_WIDTH-1:0] :
                  shifted > YMAX ? YMAX[DATA_WIDTH-1:0] :
                  shifted < YMIN ? YMIN[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            taps_valid <= 1'b0;
            tap_cnt    <= '0;
            ch         <= '0;
            remaining  <= '0;
            rshift     <= '0;
            rnd        <= 1'b0;
            sat        <= 1'b0;
            y_valid_o  <= 1'b0;
            y_data_o   <= '0;
            y_chan_o   <= '0;
            done_o     <= 1'b0;
            for (int k = 0; k < NB_TAPS; k++) taps[k] <= '0;
            for (int c = 0; c < NB_CHANNELS; c++)
                for (int k = 0; k < NB_TAPS-1; k++) dl[c][k] <= '0;
        end else begin
            state_q <= state_d;
            done_o  <= last && !clear_i;
            if (clear_i) begin
                taps_valid <= 1'b0;
                tap_cnt    <= '0;
                ch         <= '0;
                remaining  <= '0;
                y_valid_o  <= 1'b0;
                for (int c = 0; c < NB_CHANNELS; c++)
                    for (int k = 0; k < NB_TAPS-1; k++) dl[c][k] <= '0;
            end else begin
                if (state_q == IDLE && start_i) begin
                    remaining <= 32'(length_i) * 32'(NB_CHANNELS);
                    rshift    <= right_shift_i;
                    rnd       <= round_i;
                    sat       <= saturate_i;
                    ch        <= '0;
                    tap_cnt   <= '0;
                    for (int c = 0; c < NB_CHANNELS; c++)
                        for (int k = 0; k < NB_TAPS-1; k++) dl[c][k] <= '0;
                end
                if (h_fire) begin
                    taps[tap_cnt] <= $signed(h_data_i);
                    tap_cnt       <= tap_cnt + 1'b1;
                    if (tap_cnt == TW'(NB_TAPS-1)) taps_valid <= 1'b1;
                end
                if (x_fire) begin
                    remaining <= remaining - 1;
                    ch        <= ch == CH_WIDTH'(NB_CHANNELS-1) ? '0 : ch + 1'b1;
                    dl[ch][0] <= $signed(x_data_i);
                    for (int k = 1; k < NB_TAPS-1; k++) dl[ch][k] <= dl[ch][k-1];
                    y_valid_o <= 1'b1;
                    y_data_o  <= y_next;
                    y_chan_o  <= ch;
                end else if (y_fire) begin
                    y_valid_o <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_mc_engine.sv
// tb_fir_mc_engine: randomized self-checking bench for fir_mc_engine (4 taps, 2 channels)
module tb_fir_mc_engine;
    localparam int DW = 16, NT = 4, NC = 2, AW = 2*DW + 2;

    logic        clk = 0, rst_ni = 0, clear_i = 0, start_i = 0, reload_taps_i = 0;
    logic [15:0] length_i = 0;
    logic [5:0]  right_shift_i = 0;
    logic        round_i = 0, saturate_i = 0;
    logic        h_valid_i = 0, h_ready_o, x_valid_i = 0, x_ready_o, y_valid_o, y_ready_i = 0;
    logic [15:0] h_data_i = 0, x_data_i = 0, y_data_o;
    logic [0:0]  y_chan_o;
    logic        busy_o, done_o;

    fir_mc_engine #(.DATA_WIDTH(DW), .NB_TAPS(NT), .NB_CHANNELS(NC)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .reload_taps_i(reload_taps_i), .length_i(length_i), .right_shift_i(right_shift_i),
        .round_i(round_i), .saturate_i(saturate_i),
        .h_valid_i(h_valid_i), .h_ready_o(h_ready_o), .h_data_i(h_data_i),
        .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_data_i(x_data_i),
        .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .y_data_o(y_data_o), .y_chan_o(y_chan_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int          vecs = 0, errs = 0;
    int          taps_tx[NT], taps_mdl[NT];
    bit          taps_ok = 0;
    int          xs[$];
    logic [15:0] exp_d[$], got_d[$];
    int          exp_c[$], got_c[$];
    int          h_cnt, lat, stab_err, xr_err;
    bit          done_seen, timeout;

    // y[i] for interleaved sample i: plain convolution over that channel's history, then rescale
    function automatic void model(int rs, bit rn, bit st);
        exp_d.delete();
        exp_c.delete();
        for (int i = 0; i < xs.size(); i++) begin
            int c = i % NC, n = i / NC, s;
            longint acc = 0;
            for (int k = 0; k < NT; k++)
                if (n - k >= 0) acc += longint'(taps_mdl[k]) * longint'(xs[(n-k)*NC + c]);
            s = rs > AW - 1 ? AW - 1 : rs;
            if (rn && s > 0) acc += longint'(1) <<< (s - 1);
            acc = acc >>> s;
            if (st) acc = acc > 32767 ? 32767 : acc < -32768 ? -32768 : acc;
            exp_d.push_back(16'(acc));
            exp_c.push_back(c);
        end
    endfunction

    // runs one job from the current negedge until done_o is seen; leaves time in the done cycle
    task automatic run_job(int len, bit reload, int rs, bit rn, bit st, bit rand_flow, int stall_at);
        int hi = 0, xi = 0, cyc = 0, last_y = -1, stall_left = -1;
        logic [15:0] pd = 0;
        logic pc = 0;
        bit hold = 0;
        got_d.delete();
        got_c.delete();
        h_cnt = 0; done_seen = 0; timeout = 0; lat = -1; stab_err = 0; xr_err = 0;
        start_i = 1; reload_taps_i = reload; length_i = 16'(len);
        right_shift_i = 6'(rs); round_i = rn; saturate_i = st;
        @(negedge clk);
        start_i = 0;
        length_i = 16'($urandom); right_shift_i = 6'($urandom); round_i = ~rn; saturate_i = ~st;
        while (!done_seen && cyc < 3000) begin
            h_valid_i = !rand_flow || $urandom_range(0, 2) != 0;
            h_data_i  = hi < NT ? 16'(taps_tx[hi]) : 16'($urandom);
            x_valid_i = xi < xs.size() && (!rand_flow || $urandom_range(0, 2) != 0);
            x_data_i  = xi < xs.size() ? 16'(xs[xi]) : 16'($urandom);
            if (stall_at >= 0 && stall_left < 0 && got_d.size() == stall_at) stall_left = 5;
            y_ready_i = stall_left > 0 ? 1'b0 : (!rand_flow || $urandom_range(0, 2) != 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (hold && (y_valid_o !== 1'b1 || y_data_o !== pd || y_chan_o !== pc)) stab_err++;
            if (y_valid_o && !y_ready_i && x_ready_o) xr_err++;
            hold = y_valid_o && !y_ready_i;
            pd = y_data_o;
            pc = y_chan_o;
            if (done_o) begin
                done_seen = 1;
                lat = cyc - last_y;
            end
            if (h_valid_i && h_ready_o) begin
                h_cnt++;
                hi++;
            end
            if (x_valid_i && x_ready_o) xi++;
            if (y_valid_o && y_ready_i) begin
                got_d.push_back(y_data_o);
                got_c.push_back(int'(y_chan_o));
                last_y = cyc;
            end
            if (!done_seen) begin
                @(negedge clk);
                cyc++;
            end
        end
        h_valid_i = 0; x_valid_i = 0;
        timeout = !done_seen;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++;
        if ({h_ready_o, x_ready_o, y_valid_o, y_data_o, y_chan_o, busy_o, done_o} !== 22'd0) begin
            errs++;
            $display("FAIL reset outputs got %b exp all zero",
                     {h_ready_o, x_ready_o, y_valid_o, y_data_o, y_chan_o, busy_o, done_o});
        end
        rst_ni = 1;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        int e[10] = '{1, 0, 2, 0, 3, 0, 4, 0, 0, 0};
        taps_tx = '{1, 2, 3, 4};
        xs = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_job(5, 1, 0, 0, 1, 1, -1);
        vecs++;
        if (timeout || got_d.size() != 10) begin
            errs++;
            $display("FAIL impulse count got %0d exp 10 (timeout=%0d)", got_d.size(), timeout);
        end
        foreach (e[i]) if (i < got_d.size()) begin
            vecs++;
            if (got_d[i] !== 16'(e[i]) || got_c[i] != i % NC) begin
                errs++;
                $display("FAIL impulse y[%0d] got %h ch%0d exp %h ch%0d", i, got_d[i], got_c[i], 16'(e[i]), i % NC);
            end
        end
        vecs++;
        if (lat != 1) begin errs++; $display("FAIL impulse done latency got %0d exp 1", lat); end
        vecs++;
        if (h_cnt != NT) begin errs++; $display("FAIL impulse tap handshakes got %0d exp %0d", h_cnt, NT); end
        taps_mdl = taps_tx;
        taps_ok = 1;
    endtask

    task automatic test_channels();
        int e[4] = '{1, 10, 3, 30};
        taps_tx = '{1, 1, 0, 0};
        xs = '{1, 10, 2, 20};
        run_job(2, 1, 0, 0, 0, 1, -1);
        vecs++;
        if (timeout || got_d.size() != 4) begin errs++; $display("FAIL channels count got %0d exp 4", got_d.size()); end
        foreach (e[i]) if (i < got_d.size()) begin
            vecs++;
            if (got_d[i] !== 16'(e[i]) || got_c[i] != i % NC) begin
                errs++;
                $display("FAIL channels y[%0d] got %h ch%0d exp %h ch%0d", i, got_d[i], got_c[i], 16'(e[i]), i % NC);
            end
        end
        taps_mdl = taps_tx;
    endtask

    task automatic test_saturate();
        logic [15:0] e[2] = '{16'h7FFF, 16'h0001};
        taps_tx = '{32767, 32767, 32767, 32767};
        xs = '{32767, 32767};
        for (int j = 0; j < 2; j++) begin
            run_job(1, j == 0, 0, 0, j == 0, 1, -1);
            vecs++;
            if (timeout || got_d.size() != 2) begin errs++; $display("FAIL saturate%0d count got %0d exp 2", j, got_d.size()); end
            for (int i = 0; i < got_d.size(); i++) begin
                vecs++;
                if (got_d[i] !== e[j]) begin errs++; $display("FAIL saturate%0d y[%0d] got %h exp %h", j, i, got_d[i], e[j]); end
            end
        end
        vecs++;
        if (h_cnt != 0) begin errs++; $display("FAIL saturate reuse handshakes got %0d exp 0", h_cnt); end
        taps_mdl = taps_tx;
    endtask

    task automatic test_rounding();
        int          rs_t[4] = '{1, 1, 63, 63};
        bit          rn_t[4] = '{0, 1, 1, 0};
        logic [15:0] e0[4]   = '{16'h0001, 16'h0002, 16'h0000, 16'h0000};
        logic [15:0] e1[4]   = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFF};
        taps_tx = '{3, 0, 0, 0};
        xs = '{1, -1};
        for (int j = 0; j < 4; j++) begin
            run_job(1, j == 0, rs_t[j], rn_t[j], 0, 1, -1);
            vecs++;
            if (timeout || got_d.size() != 2 || got_d[0] !== e0[j] || got_d[1] !== e1[j]) begin
                errs++;
                $display("FAIL round shift=%0d rnd=%0d got %h,%h exp %h,%h", rs_t[j], rn_t[j],
                         got_d.size() > 0 ? got_d[0] : 16'hxxxx, got_d.size() > 1 ? got_d[1] : 16'hxxxx, e0[j], e1[j]);
            end
        end
        taps_mdl = taps_tx;
    endtask

    task automatic test_stall();
        taps_tx = '{-7, 300, 25, -1000};
        xs.delete();
        repeat (12) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
        run_job(6, 1, 3, 1, 1, 0, 3);
        taps_mdl = taps_tx;
        model(3, 1, 1);
        vecs++;
        if (timeout || got_d.size() != exp_d.size()) begin errs++; $display("FAIL stall count got %0d exp %0d", got_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            vecs++;
            if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i]) begin
                errs++;
                $display("FAIL stall y[%0d] got %h ch%0d exp %h ch%0d", i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
            end
        end
        vecs++;
        if (stab_err != 0 || xr_err != 0) begin
            errs++;
            $display("FAIL stall hold got %0d unstable/%0d x_ready cycles exp 0/0", stab_err, xr_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] first[$];
        foreach (taps_tx[k]) taps_tx[k] = int'($urandom_range(0, 65535)) - 32768;
        xs.delete();
        repeat (6) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
        run_job(3, 1, 15, 1, 1, 1, -1);
        first = got_d;
        taps_mdl = taps_tx;
        model(15, 1, 1);
        run_job(3, 0, 15, 1, 1, 1, -1);
        vecs++;
        if (timeout || h_cnt != 0 || got_d.size() != exp_d.size() || first.size() != exp_d.size()) begin
            errs++;
            $display("FAIL b2b got %0d/%0d outputs, %0d taps exp %0d/%0d outputs, 0 taps",
                     first.size(), got_d.size(), h_cnt, exp_d.size(), exp_d.size());
        end
        foreach (exp_d[i]) if (i < got_d.size() && i < first.size()) begin
            vecs++;
            if (got_d[i] !== exp_d[i] || first[i] !== exp_d[i]) begin
                errs++;
                $display("FAIL b2b y[%0d] got %h then %h exp %h", i, first[i], got_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_len0();
        xs.delete();
        for (int j = 0; j < 2; j++) begin
            run_job(0, j == 0, 0, 0, 0, 1, -1);
            vecs++;
            if (timeout || got_d.size() != 0 || h_cnt != (j == 0 ? NT : 0)) begin
                errs++;
                $display("FAIL len0 reload=%0d got %0d outputs %0d taps done=%0d exp 0 outputs %0d taps done=1",
                         j == 0, got_d.size(), h_cnt, done_seen, j == 0 ? NT : 0);
            end
        end
        taps_mdl = taps_tx;
    endtask

    task automatic test_clear();
        int dones = 0;
        start_i = 1; reload_taps_i = 0; length_i = 4; right_shift_i = 0;
        @(negedge clk);
        start_i = 0; x_valid_i = 1; x_data_i = 16'($urandom); y_ready_i = 1;
        repeat (3) @(negedge clk);
        clear_i = 1;
        @(negedge clk);
        clear_i = 0; x_valid_i = 0;
        #1;
        vecs++;
        if ({busy_o, y_valid_o, x_ready_o, done_o} !== 4'b0) begin
            errs++;
            $display("FAIL clear busy/yv/xr/done got %b exp 0000", {busy_o, y_valid_o, x_ready_o, done_o});
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            dones += int'(done_o);
        end
        vecs++;
        if (dones != 0) begin errs++; $display("FAIL clear spurious done got %0d exp 0", dones); end
        taps_ok = 0;
        foreach (taps_tx[k]) taps_tx[k] = int'($urandom_range(0, 255)) - 128;
        xs = '{5, -6, 7, -8};
        run_job(2, 0, 1, 0, 1, 1, -1);
        taps_mdl = taps_tx;
        taps_ok = 1;
        model(1, 0, 1);
        vecs++;
        if (timeout || h_cnt != NT || got_d != exp_d) begin
            errs++;
            $display("FAIL clear reload got %0d taps %p exp %0d taps %p", h_cnt, got_d, NT, exp_d);
        end
    endtask

    task automatic test_reset_midjob();
        taps_tx = '{9, -9, 4, 2};
        start_i = 1; reload_taps_i = 1; length_i = 3;
        @(negedge clk);
        start_i = 0; h_valid_i = 1; h_data_i = 16'd77;
        @(negedge clk);
        #2 rst_ni = 0;
        #1;
        vecs++;
        if ({busy_o, h_ready_o, y_valid_o} !== 3'b0) begin
            errs++;
            $display("FAIL reset abort busy/hr/yv got %b exp 000", {busy_o, h_ready_o, y_valid_o});
        end
        @(negedge clk);
        rst_ni = 1; h_valid_i = 0;
        @(negedge clk);
        taps_ok = 0;
        xs = '{100, 200, -300, 400};
        run_job(2, 0, 0, 0, 0, 1, -1);
        taps_mdl = taps_tx;
        taps_ok = 1;
        model(0, 0, 0);
        vecs++;
        if (timeout || h_cnt != NT || got_d != exp_d) begin
            errs++;
            $display("FAIL reset reload got %0d taps %p exp %0d taps %p", h_cnt, got_d, NT, exp_d);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            int len = $urandom_range(1, 6);
            int rs = $urandom_range(0, 40);
            bit rl = (j == 0) || ($urandom_range(0, 1) == 1);
            bit rn = $urandom_range(0, 1) == 1;
            bit st = $urandom_range(0, 1) == 1;
            int eh = (rl || !taps_ok) ? NT : 0;
            if (rl) foreach (taps_tx[k]) taps_tx[k] = int'($urandom_range(0, 65535)) - 32768;
            xs.delete();
            repeat (len * NC) xs.push_back(int'($urandom_range(0, 65535)) - 32768);
            run_job(len, rl, rs, rn, st, 1, $urandom_range(0, 1) == 1 ? 2 : -1);
            if (eh != 0) taps_mdl = taps_tx;
            taps_ok = 1;
            model(rs, rn, st);
            vecs++;
            if (timeout || h_cnt != eh || got_d.size() != exp_d.size() || lat != 1 || stab_err != 0) begin
                errs++;
                $display("FAIL random%0d got %0d taps %0d outputs lat %0d unstable %0d exp %0d taps %0d outputs lat 1 unstable 0",
                         j, h_cnt, got_d.size(), lat, stab_err, eh, exp_d.size());
            end
            foreach (exp_d[i]) if (i < got_d.size()) begin
                vecs++;
                if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i]) begin
                    errs++;
                    $display("FAIL random%0d y[%0d] got %h ch%0d exp %h ch%0d", j, i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_channels();
        test_saturate();
        test_rounding();
        test_stall();
        test_back_to_back();
        test_len0();
        test_clear();
        test_reset_midjob();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
